uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART byte transmitter among NUM_REQ byte producers.
- Grants one requester at a time and holds the grant across a burst of bytes until the requester marks the last byte.
- Caps each grant at MAX_BURST bytes, or releases it on an idle timeout.
- Sequences the transmitter with a one-cycle start pulse and waits for its done pulse before issuing the next byte.

---
 rtl/uart_tx_arbiter_if.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Byte-producer and transmitter handshake bundle for the UART arbiter.
// master = arbiter side, slave = requesters plus transmitter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 grant_valid;
  logic [IW-1:0]        grant_id;

  modport master (
    input  req_valid, req_data, req_last,
    input  tx_busy, tx_done,
    output req_ready, tx_start, tx_data,
    output grant_valid, grant_id
  );

  modport slave (
    output req_valid, req_data, req_last,
    output tx_busy, tx_done,
    input  req_ready, tx_start, tx_data,
    input  grant_valid, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin burst arbiter sharing one UART byte transmitter.
// Grant is held per burst, capped at MAX_BURST, revoked on idle timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  uart_tx_arbiter_if.master io_bus
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_REL
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] r_gid;
  logic          r_gv;
  logic [7:0]    r_burst_cnt;
  logic [7:0]    r_idle_cnt;
  logic          r_last;
  logic [7:0]    r_tx_data;

  logic          w_any;
  logic [IW-1:0] w_winner;
  logic          w_own_valid;
  logic          w_own_last;
  logic [7:0]    w_own_data;
  logic          w_accept;

  function automatic logic [IW-1:0] rot(
    input logic [IW-1:0] base,
    input int            k
  );
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  // Walk downward so the nearest set bit at/after rr_ptr wins last.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (io_bus.req_valid[rot(r_rr_ptr, k)]) begin
        w_any    = 1'b1;
        w_winner = rot(r_rr_ptr, k);
      end
    end
  end

  assign w_own_valid = io_bus.req_valid[r_gid];
  assign w_own_last  = io_bus.req_last[r_gid];
  assign w_own_data  = io_bus.req_data[{r_gid, 3'b000} +: 8];
  assign w_accept    = (r_state == S_ISSUE) && w_own_valid
                     && !io_bus.tx_busy && !rst;

  assign io_bus.tx_start    = w_accept;
  assign io_bus.req_ready   = {{(NUM_REQ-1){1'b0}}, w_accept} << r_gid;
  assign io_bus.tx_data     = w_accept ? w_own_data : r_tx_data;
  assign io_bus.grant_valid = r_gv;
  assign io_bus.grant_id    = r_gid;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE;
      S_ISSUE: begin
        if (w_accept) begin
          w_next = S_WAIT;
        end else if (!w_own_valid &&
                     r_idle_cnt == 8'(HOLD_TIMEOUT - 1)) begin
          w_next = S_REL;
        end
      end
      S_WAIT:  if (io_bus.tx_done) w_next = r_last ? S_REL : S_ISSUE;
      S_REL:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_gid       <= '0;
      r_gv        <= 1'b0;
      r_burst_cnt <= '0;
      r_idle_cnt  <= '0;
      r_last      <= 1'b0;
      r_tx_data   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gid       <= w_winner;
            r_gv        <= 1'b1;
            r_burst_cnt <= '0;
            r_idle_cnt  <= '0;
          end
        end
        S_ISSUE: begin
          if (w_accept) begin
            r_tx_data   <= w_own_data;
            r_last      <= w_own_last ||
                           (r_burst_cnt + 8'd1 == 8'(MAX_BURST));
            r_burst_cnt <= r_burst_cnt + 8'd1;
            r_idle_cnt  <= '0;
          end else if (!w_own_valid) begin
            r_idle_cnt  <= r_idle_cnt + 8'd1;
          end
        end
        S_REL: begin
          r_rr_ptr <= (r_gid == IW'(NUM_REQ - 1)) ? '0 : r_gid + 1'b1;
          r_gv     <= 1'b0;
          r_gid    <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte-queue requesters, a latency-model
// transmitter, and a transaction-level round-robin reference.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int HT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .MAX_BURST(MB),
    .HOLD_TIMEOUT(HT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_bus(bus)
  );

  typedef logic [8:0] q_t[$];
  typedef struct packed {
    logic [1:0] id;
    logic [7:0] d;
  } xfer_t;

  q_t    rq [N];
  xfer_t got[$];
  xfer_t exp_q[$];

  int npass = 0, nfail = 0, ntot = 0;
  int cyc_n = 0, model_ptr = 0;
  int tx_lat = 1, tx_cnt = 0;
  int done_cyc = -1, fall_cyc = -1;
  logic tx_busy_m = 1'b0, force_busy = 1'b0;

  logic         s_start, s_gv, prev_gv = 1'b0;
  logic [N-1:0] s_ready;
  logic [7:0]   s_data;
  logic [1:0]   s_gid;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    ntot++;
    assert (obs === expv) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]     = rq[i].size() > 0;
      bus.req_data[8*i+:8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
      bus.req_last[i]      = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
    end
    bus.tx_busy = tx_busy_m | force_busy;
  endtask

  // One clock: sample at negedge, then update requesters/transmitter.
  task automatic cyc();
    @(negedge clk);
    s_start = bus.tx_start;
    s_ready = bus.req_ready;
    s_data  = bus.tx_data;
    s_gv    = bus.grant_valid;
    s_gid   = bus.grant_id;
    if (s_start || s_ready != '0) begin
      chk("strobe", {s_start, s_ready}, {1'b1, N'(1) << s_gid});
      chk("start_busy", 32'(bus.tx_busy), 0);
      if (s_start) got.push_back(xfer_t'({s_gid, s_data}));
    end
    if (prev_gv && !s_gv) fall_cyc = cyc_n;
    prev_gv = s_gv;
    @(posedge clk);
    #1;
    cyc_n++;
    for (int i = 0; i < N; i++)
      if (s_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    bus.tx_done = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        bus.tx_done = 1'b1;
        tx_busy_m   = 1'b0;
        done_cyc    = cyc_n;
      end
    end
    if (s_start) begin
      if (tx_lat == 1) begin
        bus.tx_done = 1'b1;
        done_cyc    = cyc_n;
      end else begin
        tx_busy_m = 1'b1;
        tx_cnt    = tx_lat - 1;
      end
    end
    drive();
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++)
      if (rq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Grant-level model: serve bursts round-robin, ending a grant on the
  // last flag, on MB bytes, or when the owner runs dry (timeout).
  function automatic void predict();
    q_t c [N];
    int id, n;
    logic [8:0] e;
    for (int i = 0; i < N; i++) c[i] = rq[i];
    exp_q.delete();
    while (1) begin
      id = -1;
      for (int k = 0; k < N; k++)
        if (id < 0 && c[(model_ptr + k) % N].size() > 0)
          id = (model_ptr + k) % N;
      if (id < 0) break;
      n = 0;
      do begin
        e = c[id].pop_front();
        exp_q.push_back(xfer_t'({2'(id), e[7:0]}));
        n++;
      end while (!e[8] && n < MB && c[id].size() > 0);
      model_ptr = (id + 1) % N;
    end
  endfunction

  task automatic run_phase(input string tag, input int budget);
    int t = 0;
    predict();
    got.delete();
    do begin
      cyc();
      t++;
    end while ((pending() || s_gv || tx_busy_m) && t < budget);
    chk({tag, "_finished"}, 32'(t < budget), 1);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_xfer%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive();
    cyc();
    chk("rst_no_strobe", {s_start, s_ready}, 0);
    rst = 1'b0;
    model_ptr = 0;
  endtask

  function automatic void push_burst(input int id, input int len,
                                     input bit with_last);
    for (int b = 0; b < len; b++)
      rq[id].push_back({with_last && (b == len - 1), 8'($urandom)});
  endfunction

  initial begin
    int w, bad;
    bus.tx_done = 1'b0;
    drive();
    do_reset();
    cyc();
    chk("reset_out", {s_gv, s_gid, s_start, s_ready, s_data}, 0);

    // Single byte: latency, data, release timing.
    rq[0].push_back({1'b1, 8'h55});
    tx_lat = 10;
    drive();
    cyc();
    chk("t1_idle_gv", 32'(s_gv), 0);
    cyc();
    chk("t1_grant", {s_gv, s_gid}, {1'b1, 2'd0});
    chk("t1_start", {s_start, s_ready}, 5'b10001);
    chk("t1_data", s_data, 8'h55);
    cyc();
    chk("t1_hold", {s_start, s_data}, {1'b0, 8'h55});
    w = 0;
    do begin cyc(); w++; end while (s_gv && w < 40);
    chk("t1_release_gap", fall_cyc - done_cyc, 2);
    model_ptr = 1;
    rq[0].push_back({1'b1, 8'h10});
    rq[1].push_back({1'b1, 8'h11});
    drive();
    run_phase("t1_ptr", 200);

    // All four valid, single-byte bursts.
    do_reset();
    tx_lat = 10;
    push_burst(0, 1, 1);
    push_burst(0, 1, 1);
    for (int i = 1; i < N; i++) push_burst(i, 1, 1);
    drive();
    run_phase("t2", 400);

    // Three-byte burst from requester 2 while 0 waits.
    tx_lat = 4;
    rq[2].push_back({1'b0, 8'hA1});
    rq[2].push_back({1'b0, 8'hA2});
    rq[2].push_back({1'b1, 8'hA3});
    rq[0].push_back({1'b1, 8'h0F});
    drive();
    run_phase("t3", 300);

    // Burst cap: requester 1 with a 6-byte run.
    tx_lat = 2;
    push_burst(1, 6, 1);
    push_burst(0, 1, 1);
    push_burst(2, 1, 1);
    push_burst(3, 1, 1);
    drive();
    run_phase("t4", 400);

    // Randomized traffic, including runs that end without a last flag.
    for (int r = 0; r < 4; r++) begin
      tx_lat = $urandom_range(1, 6);
      for (int i = 0; i < N; i++) begin
        int nb = $urandom_range(0, 2);
        for (int b = 0; b < nb; b++)
          push_burst(i, $urandom_range(1, 6), $urandom_range(0, 4) != 0);
      end
      drive();
      run_phase($sformatf("rand%0d", r), 3000);
    end

    // Idle timeout after one byte without last.
    tx_lat = 3;
    rq[3].push_back({1'b0, 8'h77});
    drive();
    run_phase("t5", 200);
    chk("t5_timeout", fall_cyc - done_cyc, HT + 2);

    // Busy transmitter stalls ISSUE without counting toward timeout.
    tx_lat = 2;
    got.delete();
    force_busy = 1'b1;
    rq[0].push_back({1'b0, 8'hB0});
    rq[0].push_back({1'b1, 8'hB1});
    drive();
    repeat (20) cyc();
    chk("stall_gv", 32'(s_gv), 1);
    chk("stall_nostart", got.size(), 0);
    force_busy = 1'b0;
    drive();
    run_phase("stall", 200);

    // Reset while waiting on the transmitter.
    tx_lat = 12;
    rq[2].push_back({1'b1, 8'h3C});
    drive();
    w = 0;
    do begin cyc(); w++; end while (!s_start && w < 20);
    chk("t6_started", 32'(s_start), 1);
    cyc();
    cyc();
    chk("t6_wait_data", s_data, 8'h3C);
    do_reset();
    cyc();
    chk("t6_reset_out", {s_gv, s_gid, s_start, s_ready, s_data}, 0);
    bad = 0;
    w = 0;
    while (tx_busy_m && w < 30) begin
      cyc();
      w++;
      if (s_gv || s_start) bad++;
    end
    cyc();
    if (s_gv || s_start) bad++;
    chk("t6_done_ignored", bad, 0);
    push_burst(3, 1, 1);
    push_burst(1, 1, 1);
    push_burst(0, 1, 1);
    drive();
    run_phase("t6_next", 300);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
